// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
// Shared constants and types for the UART transmit-path arbiter.
//   MAX_REQ    : largest supported requester count
//   TAG_NIBBLE : upper nibble of the optional channel tag byte
//   state_t    : FSM state word, states held as plain localparam constants
// ----------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int         MAX_REQ    = 16;
    localparam logic [3:0] TAG_NIBBLE = 4'hA;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_TAG  = 2'd1;
    localparam state_t ST_XFER = 2'd2;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req starting one position after
// the last-served pointer, wrapping modulo N_REQ; the pointer position itself
// is searched last.
// Ports:
//   req   [N_REQ-1:0] : request vector
//   ptr   [IDX_W-1:0] : index of the last-served requester
//   pick  [N_REQ-1:0] : one-hot winner (zero when nothing requests)
//   idx   [IDX_W-1:0] : binary index of the winner
//   found             : at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // NOTE: every output gets a default before the search so no path through
    // the loops leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % N_REQ)) begin
                    found   = 1'b1;
                    pick[i] = 1'b1;
                    idx     = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares the UART transmit FIFO write port among N_REQ byte-stream requesters.
// Arbitration is round-robin at packet granularity: the owner keeps the path
// until it transfers a byte flagged last, so packets never interleave.
//
// Optional feature (macro UART_ARB_CHAN_TAG_EN): each packet is prefixed by a
// channel tag byte {4'hA, owner index}.
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   req_valid/req_last [N]   : per-requester byte valid / last-of-packet
//   req_data [8N]            : requester i on bits [8i+7:8i]
//   req_ready [N]            : per-requester accept (valid & ready = transfer)
//   fifo_full                : transmit FIFO full, blocks all writes
//   wr_en, data_out [8]      : transmit FIFO write strobe and byte
//   grant [N]                : one-hot current owner, zero when idle
//   busy                     : a packet is currently owned
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               fifo_full,
    output logic               wr_en,
    output logic [7:0]         data_out,
    output logic [N_REQ-1:0]   grant,
    output logic               busy
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_ptr;

    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    logic [7:0]       owner_byte;
    logic             owner_valid;
    logic             owner_last;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (last_ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Owner's signals selected by OR-ing under the one-hot grant.
    always_comb begin
        owner_byte  = 8'h00;
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                owner_byte  = owner_byte | req_data[8*i +: 8];
                owner_valid = owner_valid | req_valid[i];
                owner_last  = owner_last | req_last[i];
            end
        end
    end

`ifdef UART_ARB_CHAN_TAG_EN
    logic [3:0] tag_idx;
    assign tag_idx = 4'(grant_idx);
`endif

    // Write path is combinational so a full FIFO blocks the write in the
    // same cycle it is flagged.
    always_comb begin
        wr_en     = 1'b0;
        data_out  = 8'h00;
        req_ready = '0;
        case (state)
            ST_XFER: begin
                req_ready = grant & {N_REQ{!fifo_full}};
                wr_en     = owner_valid & !fifo_full;
                data_out  = owner_byte;
            end
`ifdef UART_ARB_CHAN_TAG_EN
            ST_TAG: begin
                wr_en    = !fifo_full;
                data_out = {TAG_NIBBLE, tag_idx};
            end
`endif
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: every register here is control state and is reset; there is no
    // storage array that could be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            last_ptr  <= IDX_W'(N_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant     <= pick;
                        grant_idx <= pick_idx;
`ifdef UART_ARB_CHAN_TAG_EN
                        state     <= ST_TAG;
`else
                        state     <= ST_XFER;
`endif
                    end
                end
`ifdef UART_ARB_CHAN_TAG_EN
                ST_TAG: begin
                    if (!fifo_full) state <= ST_XFER;
                end
`endif
                ST_XFER: begin
                    // Pointer moves only on packet completion.
                    if (wr_en && owner_last) begin
                        last_ptr <= grant_idx;
                        grant    <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Scoreboard bench: packets are queued per requester, a round-robin packet
// model predicts the FIFO byte stream, and a negedge monitor compares every
// FIFO write against it while also checking per-cycle output invariants.
// Honours UART_ARB_CHAN_TAG_EN for the expected tag bytes.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef UART_ARB_CHAN_TAG_EN
    localparam int TAGN = 1;
`else
    localparam int TAGN = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_full = 1'b0;
    logic           wr_en;
    logic [7:0]     data_out;
    logic [N-1:0]   grant;
    logic           busy;

    uart_tx_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .data_out  (data_out),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c0      = 0;

    logic [8:0]  src_q [N][$];   // {last, data} per requester
    logic [11:0] exp_q [$];      // {owner index, byte}
    int          wr_cycle [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard on each FIFO write.
    always @(negedge clk) begin
        logic [11:0] e;
        check("no_write_when_full", 32'(wr_en & fifo_full), 0);
        check("ready_only_owner", 32'(req_ready & ~grant), 0);
        check("no_ready_when_full", 32'(|req_ready & fifo_full), 0);
        check("grant_onehot0", 32'($countones(grant) <= 1), 1);
        check("busy_eq_owned", 32'(busy), 32'(grant != '0));
        if (wr_en) begin
            wr_cycle.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got byte %0h, required no write", data_out);
            end else begin
                e = exp_q.pop_front();
                check("fifo_byte", 32'(data_out), 32'(e[7:0]));
                check("write_owner", 32'(grant), 32'(4'b0001 << e[11:8]));
            end
        end
    end

    // Reference: walk packets round-robin from pointer N-1; a requester is
    // pending exactly while it still has packets queued.
    task automatic build_expected();
        logic [8:0] cp [N][$];
        logic [8:0] b;
        int ptr = N - 1;
        int sel;
        for (int i = 0; i < N; i++) cp[i] = src_q[i];
        forever begin
            sel = -1;
            for (int k = 1; k <= N; k++)
                if (sel < 0 && cp[(ptr + k) % N].size() > 0) sel = (ptr + k) % N;
            if (sel < 0) break;
            if (TAGN == 1) exp_q.push_back({4'(sel), 4'hA, 4'(sel)});
            do begin
                b = cp[sel].pop_front();
                exp_q.push_back({4'(sel), b[7:0]});
            end while (!b[8]);
            ptr = sel;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '1;
        req_data  = '1;
        req_last  = '1;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_data", 32'(data_out), 0);
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        rst_n = 1'b1;
        wr_cycle.delete();
    endtask

    task automatic drive(input bit mid [N], input int gap_pct, input int full_pct);
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                h = src_q[i][0];
                req_valid[i] = !(mid[i] && ($urandom_range(99) < gap_pct));
                req_data[8*i +: 8] = h[7:0];
                req_last[i] = h[8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
        fifo_full = ($urandom_range(99) < full_pct);
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Called right after apply_reset (posedge+1): first inputs land at cycle c0.
    task automatic run_traffic(input int budget, input int gap_pct, input int full_pct);
        logic [N-1:0] acc;
        logic [8:0]   h;
        bit mid [N];
        int n = 0;
        for (int i = 0; i < N; i++) mid[i] = 1'b0;
        c0 = cyc;
        drive(mid, gap_pct, full_pct);
        while ((any_pending() || busy) && n < budget) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    h = src_q[i].pop_front();
                    mid[i] = !h[8];
                end
            end
            drive(mid, gap_pct, full_pct);
            n++;
        end
        if (n >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL traffic_timeout: got %0d cycles, required completion within %0d", n, budget);
        end
        req_valid = '0;
        fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        check("idle_after_traffic", 32'({busy, grant}), 0);
    endtask

    initial begin
        // Single requester, 3 bytes, no back-pressure: writes on c0+1.. consecutive.
        apply_reset();
        src_q[0] = '{9'h011, 9'h022, 9'h133};
        build_expected();
        run_traffic(200, 0, 0);
        check("t1_write_count", 32'(wr_cycle.size()), 32'(3 + TAGN));
        for (int k = 0; k < wr_cycle.size(); k++)
            check("t1_write_cycle", 32'(wr_cycle[k]), 32'(c0 + 1 + k));

        // req1 and req3 contend: req1 first, exactly one idle cycle between.
        apply_reset();
        src_q[1] = '{9'h0A1, 9'h1B1};
        src_q[3] = '{9'h0A3, 9'h1B3};
        build_expected();
        run_traffic(200, 0, 0);
        check("t2_write_count", 32'(wr_cycle.size()), 32'(4 + 2 * TAGN));
        if (wr_cycle.size() == 4 + 2 * TAGN)
            check("t2_idle_gap", 32'(wr_cycle[2 + TAGN] - wr_cycle[1 + TAGN]), 2);

        // All requesters with three 1-byte packets each: strict 0,1,2,3 rotation.
        apply_reset();
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 3; p++) src_q[i].push_back({1'b1, 4'(p), 4'(i)});
        build_expected();
        run_traffic(500, 0, 0);

        // Heavy FIFO back-pressure mid-packet.
        apply_reset();
        for (int b = 0; b < 6; b++) src_q[0].push_back({b == 5, 8'(8'h40 + b)});
        src_q[1] = '{9'h155};
        build_expected();
        run_traffic(1000, 0, 60);

        // Owner drops valid mid-packet while req2 waits.
        apply_reset();
        for (int b = 0; b < 5; b++) src_q[0].push_back({b == 4, 8'(8'h70 + b)});
        src_q[2] = '{9'h1C2};
        build_expected();
        run_traffic(1000, 70, 0);

        // req2 single-byte packet AB (tag build adds A2 ahead of it).
        apply_reset();
        src_q[2] = '{9'h1AB};
        build_expected();
        run_traffic(200, 0, 0);

        // Randomized packet mixes with gaps and back-pressure.
        for (int r = 0; r < 8; r++) begin
            apply_reset();
            for (int i = 0; i < N; i++) begin
                int npk = $urandom_range(3);
                for (int p = 0; p < npk; p++) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        src_q[i].push_back({b == len - 1, 8'($urandom)});
                end
            end
            build_expected();
            run_traffic(3000, 30, 30);
        end

        // Async reset right after the packet is granted (TAG or XFER).
        apply_reset();
        req_valid[2] = 1'b1;
        req_data[23:16] = 8'hAB;
        req_last[2] = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 1);
        check("pre_rst_data", 32'(data_out), (TAGN == 1) ? 32'hA2 : 32'hAB);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 0);
        check("mid_rst_grant", 32'(grant), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_data", 32'(data_out), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        req_valid = '0;
        req_last  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 32'({busy, grant, wr_en}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, required finish before 2 ms");
        $fatal(1);
    end

endmodule
